// File: rtl/iram_axil_if.sv
// AXI4-Lite signal bundle between a bus master and the iram_axil slave port.
// The prot fields are carried for completeness; the RAM ignores them.
interface iram_axil_if;
    logic [31:0] axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;

    modport slave (
        input  axi_awaddr, axi_awprot, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wvalid,
        output axi_wready,
        output axi_bresp, axi_bvalid,
        input  axi_bready,
        input  axi_araddr, axi_arprot, axi_arvalid,
        output axi_arready,
        output axi_rdata, axi_rresp, axi_rvalid,
        input  axi_rready
    );

    modport master (
        output axi_awaddr, axi_awprot, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wvalid,
        input  axi_wready,
        input  axi_bresp, axi_bvalid,
        output axi_bready,
        output axi_araddr, axi_arprot, axi_arvalid,
        input  axi_arready,
        input  axi_rdata, axi_rresp, axi_rvalid,
        output axi_rready
    );
endinterface

// File: rtl/iram_axil.sv
// Dual-port instruction RAM: port A serves instruction fetch, port B is an AXI4-Lite slave.
// Defining IRAM_WR_LOCK_EN makes bus writes to words below LOCK_WORDS fail with SLVERR.
module iram_axil #(
    parameter int unsigned DEPTH_WORDS = 8192,
    parameter logic [31:0] RST_PC      = 32'h0000_0000,
    parameter int unsigned LOCK_WORDS  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_n_i,
    input  logic        iram_rd_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        boot_o,
    iram_axil_if.slave  axi
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] RstIdx = RST_PC[AW+1:2];

    typedef enum logic [1:0] {WIdle, WGotA, WGotD, WResp} wstate_e;

    logic [31:0] mem [DEPTH_WORDS];

    wstate_e     wstate_q, wstate_d;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic [1:0]  bresp_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    logic        aw_hs, w_hs, ar_hs;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;
    logic        wr_fire, wr_oor, wr_lock, wr_en;
    logic        rd_oor;

    assign axi.axi_awready = ~rst & ((wstate_q == WIdle) | (wstate_q == WGotD));
    assign axi.axi_wready  = ~rst & ((wstate_q == WIdle) | (wstate_q == WGotA));
    assign axi.axi_arready = ~rst & (~rvalid_q | axi.axi_rready);
    assign axi.axi_bvalid  = (wstate_q == WResp);
    assign axi.axi_bresp   = bresp_q;
    assign axi.axi_rvalid  = rvalid_q;
    assign axi.axi_rdata   = rdata_q;
    assign axi.axi_rresp   = rresp_q;

    assign aw_hs = axi.axi_awvalid & axi.axi_awready;
    assign w_hs  = axi.axi_wvalid & axi.axi_wready;
    assign ar_hs = axi.axi_arvalid & axi.axi_arready;

    // Whichever half arrived earlier comes from its holding register.
    assign wr_addr = (wstate_q == WGotA) ? aw_addr_q : axi.axi_awaddr;
    assign wr_data = (wstate_q == WGotD) ? w_data_q : axi.axi_wdata;
    assign wr_strb = (wstate_q == WGotD) ? w_strb_q : axi.axi_wstrb;
    assign wr_oor  = |wr_addr[31:AW+2];
    assign rd_oor  = |axi.axi_araddr[31:AW+2];

`ifdef IRAM_WR_LOCK_EN
    assign wr_lock = ({2'b00, wr_addr[31:2]} < LOCK_WORDS);
`else
    logic unused_lock;
    assign wr_lock     = 1'b0;
    assign unused_lock = ^LOCK_WORDS;
`endif

    assign wr_en = wr_fire & ~wr_oor & ~wr_lock;

    logic unused_prot;
    assign unused_prot = ^{axi.axi_awprot, axi.axi_arprot};

    always_comb begin
        wstate_d = wstate_q;
        wr_fire  = 1'b0;
        unique case (wstate_q)
            WIdle: begin
                if (aw_hs && w_hs) begin
                    wr_fire  = 1'b1;
                    wstate_d = WResp;
                end else if (aw_hs) begin
                    wstate_d = WGotA;
                end else if (w_hs) begin
                    wstate_d = WGotD;
                end
            end
            WGotA: begin
                if (w_hs) begin
                    wr_fire  = 1'b1;
                    wstate_d = WResp;
                end
            end
            WGotD: begin
                if (aw_hs) begin
                    wr_fire  = 1'b1;
                    wstate_d = WResp;
                end
            end
            WResp: begin
                if (axi.axi_bready) wstate_d = WIdle;
            end
            default: wstate_d = WIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q  <= WIdle;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= 2'b00;
        end else begin
            wstate_q <= wstate_d;
            if (aw_hs) aw_addr_q <= axi.axi_awaddr;
            if (w_hs) begin
                w_data_q <= axi.axi_wdata;
                w_strb_q <= axi.axi_wstrb;
            end
            if (wr_fire) bresp_q <= (wr_oor || wr_lock) ? 2'b10 : 2'b00;
        end
    end

    // RAM contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) mem[wr_addr[AW+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_oor ? 32'h0 : mem[axi.axi_araddr[AW+1:2]];
            rresp_q  <= rd_oor ? 2'b10 : 2'b00;
        end else if (axi.axi_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    // The boot cycle loads the reset vector word so the core sees it as boot_o drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o   <= RST_PC;
            inst_o <= '0;
            boot_o <= 1'b1;
        end else if (boot_o) begin
            pc_o   <= RST_PC;
            inst_o <= mem[RstIdx];
            boot_o <= 1'b0;
        end else if (iram_rd_i) begin
            pc_o   <= pc_n_i;
            inst_o <= mem[pc_n_i[AW+1:2]];
        end
    end
endmodule
